// File: rtl/ws2812b_frame_sequencer.sv
// Frame sequencer for the WS2812B serialiser: streams led_count pixels from a
// small GRB pattern buffer, wrapping modulo DEPTH, with a global brightness shift.
module ws2812b_frame_sequencer #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_we,
  input  logic [IDX_W-1:0] pix_idx,
  input  logic [1:0]       pix_sel,
  input  logic [7:0]       pix_wdata,
  output logic [7:0]       pix_rdata,
  input  logic [7:0]       led_count,
  input  logic [2:0]       bright_shift,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [23:0]      drv_data,
  output logic             drv_valid,
  output logic             drv_latch,
  input  logic             drv_ready
);

  // Handshake: a pixel is offered with drv_valid=1 once drv_ready=1 is seen in
  // FETCH; it is held stable until the serialiser drops drv_ready, which marks
  // acceptance. drv_latch is only meaningful while drv_valid=1.
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       pat_g [DEPTH];
  logic [7:0]       pat_r [DEPTH];
  logic [7:0]       pat_b [DEPTH];
  logic [7:0]       rem;
  logic [2:0]       shift;
  logic [IDX_W-1:0] ptr;
  logic             abort_pend;
  logic             accept;

  assign busy   = (state_q != IDLE);
  assign accept = (state_q == ISSUE) && !drv_ready;

  // Pattern buffer is deliberately not reset; writes are locked out during a frame.
  always_ff @(posedge clk) begin
    if (pix_we && !busy) begin
      case (pix_sel)
        2'd0:    pat_g[pix_idx] <= pix_wdata;
        2'd1:    pat_r[pix_idx] <= pix_wdata;
        2'd2:    pat_b[pix_idx] <= pix_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (pix_sel)
      2'd0:    pix_rdata = pat_g[pix_idx];
      2'd1:    pix_rdata = pat_r[pix_idx];
      2'd2:    pix_rdata = pat_b[pix_idx];
      default: pix_rdata = 8'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start && led_count != 8'd0) state_d = FETCH;
      FETCH: begin
        if (abort)          state_d = IDLE;
        else if (drv_ready) state_d = ISSUE;
      end
      ISSUE: begin
        if (accept) begin
          if (rem == 8'd1 || abort || abort_pend) state_d = IDLE;
          else                                    state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem        <= 8'd0;
      shift      <= 3'd0;
      ptr        <= '0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
      drv_data   <= 24'd0;
      drv_valid  <= 1'b0;
      drv_latch  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          abort_pend <= 1'b0;
          if (start) begin
            rem   <= led_count;
            shift <= bright_shift;
            ptr   <= '0;
            if (led_count == 8'd0) done <= 1'b1;
          end
        end
        FETCH: begin
          drv_data <= {pat_g[ptr] >> shift, pat_r[ptr] >> shift, pat_b[ptr] >> shift};
          if (!abort && drv_ready) begin
            drv_valid <= 1'b1;
            drv_latch <= (rem == 8'd1);
          end
        end
        ISSUE: begin
          if (accept) begin
            drv_valid  <= 1'b0;
            drv_latch  <= 1'b0;
            rem        <= rem - 8'd1;
            ptr        <= ptr + IDX_W'(1);
            abort_pend <= 1'b0;
            if (rem == 8'd1) done <= 1'b1;
          end else if (abort) begin
            // Abort cannot retract a live pixel; remember it for the boundary.
            abort_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// Bench for ws2812b_frame_sequencer: reactive serialiser model, frame-level
// reference model of expected pixels, scoreboard queue and summary.
module tb_ws2812b_frame_sequencer;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pix_we = 1'b0;
  logic [IDX_W-1:0] pix_idx = '0;
  logic [1:0]       pix_sel = 2'd0;
  logic [7:0]       pix_wdata = 8'd0;
  logic [7:0]       pix_rdata;
  logic [7:0]       led_count = 8'd0;
  logic [2:0]       bright_shift = 3'd0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy, done, drv_valid, drv_latch;
  logic [23:0]      drv_data;
  logic             drv_ready = 1'b1;

  ws2812b_frame_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .pix_we(pix_we), .pix_idx(pix_idx), .pix_sel(pix_sel),
    .pix_wdata(pix_wdata), .pix_rdata(pix_rdata), .led_count(led_count),
    .bright_shift(bright_shift), .start(start), .abort(abort), .busy(busy), .done(done),
    .drv_data(drv_data), .drv_valid(drv_valid), .drv_latch(drv_latch), .drv_ready(drv_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hold = 2;
  int hold_cnt = 0;
  int valid_cnt = 0;
  int done_cnt = 0;
  int extra_cnt = 0;
  logic [31:0] exp_q[$];
  logic [7:0] m_g [DEPTH];
  logic [7:0] m_r [DEPTH];
  logic [7:0] m_b [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected pixel i of a frame: entry i mod DEPTH, each channel shifted, latch on last.
  function automatic logic [31:0] pix(input int i, input int s, input bit last);
    int k;
    logic [7:0] g, r, b;
    k = i % DEPTH;
    g = m_g[k] >> s;
    r = m_r[k] >> s;
    b = m_b[k] >> s;
    return {7'd0, last, g, r, b};
  endfunction

  // Serialiser model: takes a pixel when valid&&ready, then stays busy for `hold` cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      drv_ready = 1'b1;
      hold_cnt  = 0;
    end else begin
      if (done) done_cnt++;
      if (drv_ready && drv_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) extra_cnt++;
        else check("pixel", {7'd0, drv_latch, drv_data}, exp_q.pop_front());
        drv_ready = 1'b0;
        hold_cnt  = hold;
      end else if (!drv_ready) begin
        if (hold_cnt > 1) hold_cnt--;
        else drv_ready = 1'b1;
      end
    end
  end

  task automatic wr(input int idx, input int sel, input logic [7:0] d);
    @(negedge clk);
    pix_we = 1'b1; pix_idx = IDX_W'(idx); pix_sel = 2'(sel); pix_wdata = d;
    if (!busy) begin
      if (sel == 0) m_g[idx] = d;
      if (sel == 1) m_r[idx] = d;
      if (sel == 2) m_b[idx] = d;
    end
    @(negedge clk);
    pix_we = 1'b0;
  endtask

  task automatic wr_entry(input int idx, input logic [23:0] grb);
    wr(idx, 0, grb[23:16]);
    wr(idx, 1, grb[15:8]);
    wr(idx, 2, grb[7:0]);
  endtask

  task automatic run_frame(input int n, input int s, input int hd);
    int cyc, d0, budget;
    hold = hd;
    for (int i = 0; i < n; i++) exp_q.push_back(pix(i, s, i == n - 1));
    d0 = done_cnt;
    extra_cnt = 0;
    budget = n * (hd + 6) + 20;
    @(negedge clk);
    led_count = 8'(n); bright_shift = 3'(s); start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end while (!drv_valid && cyc < budget);
    check("first_latency", cyc, 2);
    cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      @(negedge clk); #1;
      cyc++;
    end
    repeat (3) @(negedge clk);
    #1;
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after", busy, 0);
    check("valid_after", drv_valid, 0);
    check("pixels_left", exp_q.size(), 0);
    check("extra_pixels", extra_cnt, 0);
  endtask

  initial begin
    int v0, d0, cyc;
    logic [31:0] e1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", {drv_valid, drv_latch}, 0);
    check("rst_data", drv_data, 0);
    rst_n = 1'b1;

    // Two-pixel frame, no shift.
    wr_entry(0, 24'h102030);
    wr_entry(1, 24'hFF0080);
    @(negedge clk); pix_idx = 3'd1; pix_sel = 2'd2; #1;
    check("rdata_b1", pix_rdata, 8'h80);
    pix_sel = 2'd3; #1;
    check("rdata_none", pix_rdata, 8'h00);
    wr(1, 3, 8'h55);
    pix_idx = 3'd1; pix_sel = 2'd1; #1;
    check("rdata_r1_sel3", pix_rdata, 8'h00);
    run_frame(2, 0, 2);

    // Ten pixels over eight distinct entries: wraps to entries 0 and 1.
    for (int i = 0; i < DEPTH; i++) wr_entry(i, {8'(i * 16 + 1), 8'(i * 16 + 2), 8'(i * 16 + 3)});
    run_frame(10, 0, 3);

    // Brightness shift of 3.
    wr_entry(0, 24'hF80807);
    run_frame(1, 3, 1);

    // Random buffers, lengths, shifts and serialiser speeds.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < DEPTH; i++) wr_entry(i, 24'($urandom));
      run_frame($urandom_range(1, 20), $urandom_range(0, 7), $urandom_range(1, 4));
    end

    // Zero-length frame.
    v0 = valid_cnt;
    @(negedge clk); led_count = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    @(posedge clk); #1;
    check("zero_done_1cyc", done, 0);
    repeat (5) @(negedge clk);
    check("zero_no_valid", valid_cnt - v0, 0);

    // Abort at the second pixel's acceptance with a slow serialiser.
    hold = 50;
    for (int i = 0; i < 2; i++) exp_q.push_back(pix(i, 0, 1'b0));
    v0 = valid_cnt; d0 = done_cnt; extra_cnt = 0;
    @(negedge clk); led_count = 8'd5; bright_shift = 3'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (valid_cnt - v0 < 2 && cyc < 400) begin
      @(negedge clk); #1;
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    check("abort_valids", valid_cnt - v0, 2);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_busy", busy, 0);
    check("abort_extra", extra_cnt, 0);
    check("abort_left", exp_q.size(), 0);

    // Write and start during busy, then reset during the second pixel.
    hold = 50;
    for (int i = 0; i < 3; i++) exp_q.push_back(pix(i, 1, i == 2));
    e1 = pix(1, 1, 1'b0);
    @(negedge clk); led_count = 8'd3; bright_shift = 3'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!drv_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    pix_we = 1'b1; pix_idx = 3'd0; pix_sel = 2'd0; pix_wdata = ~m_g[0];
    start = 1'b1; led_count = 8'd7;
    @(posedge clk); #1;
    pix_we = 1'b0; start = 1'b0;
    cyc = 0;
    while (!drv_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_2nd_pixel", {7'd0, drv_latch, drv_data}, e1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", drv_valid, 0);
    check("rst_mid_busy", busy, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    pix_idx = 3'd0; pix_sel = 2'd0; #1;
    check("busy_write_ignored", pix_rdata, m_g[0]);
    repeat (6) @(negedge clk);
    #1;
    check("no_restart", {busy, drv_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
